// File: rtl/soc_bus_pkg.sv
// Shared peripheral-bus definitions: device-id map, arbiter state encoding and the
// mapped-address check. device_sel imports the same package so both sides decode
// the device id identically.
package soc_bus_pkg;

  localparam logic [3:0] DEV_RAM   = 4'h0;
  localparam logic [3:0] DEV_GPIO  = 4'h4;
  localparam logic [3:0] DEV_UART  = 4'h5;
  localparam logic [3:0] DEV_TIMER = 4'h6;
  localparam logic [3:0] DEV_SPI   = 4'h8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBusy  = 2'd1,
    StFault = 2'd2
  } bus_state_e;

  // True when the device id (addr[31:28]) has a device behind it.
  function automatic logic is_mapped(input logic [3:0] dev_id);
    case (dev_id)
      DEV_RAM, DEV_GPIO, DEV_UART, DEV_TIMER, DEV_SPI: is_mapped = 1'b1;
      default:                                          is_mapped = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   en_i          : arbitration allowed this cycle
//   req_i[1:0]    : request per master
//   gnt_o[1:0]    : one-hot grant (combinational)
// On contention the master not granted most recently wins; after reset M0 is favoured.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  // 1: M1 has priority on contention, 0: M0 has priority.
  logic prio_m1_q;

  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      if (req_i[0] && (!req_i[1] || !prio_m1_q)) begin
        gnt_o[0] = 1'b1;
      end else if (req_i[1]) begin
        gnt_o[1] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_m1_q <= 1'b0;
    end else if (|gnt_o) begin
      prio_m1_q <= gnt_o[0];
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master arbiter and transaction sequencer for the SoC peripheral bus.
//   i_clk, i_rst_n         : clock, asynchronous active-low reset
//   i_mX_req/we/addr/wdata : master X command, held until o_mX_gnt
//   o_mX_gnt               : command accepted this cycle (combinational)
//   o_mX_done/err/rdata    : registered completion pulse, error flag, read data
//   o_bus_valid/we/addr/wdata/owner : registered command towards device_sel
//   i_bus_rdata, i_bus_ready        : device response
// Unmapped addresses never reach the bus; a device that never answers is aborted after
// the command has been on the bus for TIMEOUT+1 cycles.
module bus_arbiter
  import soc_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = $clog2(TIMEOUT + 1)
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_m0_req,
  input  logic        i_m0_we,
  input  logic [31:0] i_m0_addr,
  input  logic [31:0] i_m0_wdata,
  output logic        o_m0_gnt,
  output logic        o_m0_done,
  output logic        o_m0_err,
  output logic [31:0] o_m0_rdata,
  input  logic        i_m1_req,
  input  logic        i_m1_we,
  input  logic [31:0] i_m1_addr,
  input  logic [31:0] i_m1_wdata,
  output logic        o_m1_gnt,
  output logic        o_m1_done,
  output logic        o_m1_err,
  output logic [31:0] o_m1_rdata,
  output logic        o_bus_valid,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [31:0] o_bus_wdata,
  input  logic [31:0] i_bus_rdata,
  input  logic        i_bus_ready,
  output logic        o_bus_owner
);

  bus_state_e      state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [1:0]      gnt;
  logic            accept;
  logic            sel_we;
  logic [31:0]     sel_addr, sel_wdata;
  logic            fin, fin_err;
  logic            upd_rdata;
  logic [31:0]     fin_rdata;
  logic            owner_q, we_q;
  logic [31:0]     addr_q, wdata_q;
  logic [1:0]      done_q, err_q, done_d, err_d;
  logic [31:0]     rdata0_q, rdata1_q, rdata0_d, rdata1_d;

  // Gating with i_rst_n keeps the grants low while reset is held.
  rr_arb2 u_arb (
    .clk_i  (i_clk),
    .rst_ni (i_rst_n),
    .en_i   ((state_q == StIdle) && i_rst_n),
    .req_i  ({i_m1_req, i_m0_req}),
    .gnt_o  (gnt)
  );

  assign accept    = |gnt;
  assign sel_we    = gnt[1] ? i_m1_we    : i_m0_we;
  assign sel_addr  = gnt[1] ? i_m1_addr  : i_m0_addr;
  assign sel_wdata = gnt[1] ? i_m1_wdata : i_m0_wdata;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fin     = 1'b0;
    fin_err = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          cnt_d   = '0;
          state_d = is_mapped(sel_addr[31:28]) ? StBusy : StFault;
        end
      end
      StBusy: begin
        if (i_bus_ready) begin
          fin     = 1'b1;
          cnt_d   = '0;
          state_d = StIdle;
        end else if (cnt_q == TO_W'(TIMEOUT)) begin
          fin     = 1'b1;
          fin_err = 1'b1;
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      StFault: begin
        fin     = 1'b1;
        fin_err = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Errors force rdata to zero; successful writes leave it untouched.
  assign upd_rdata = fin && (fin_err || !we_q);
  assign fin_rdata = fin_err ? 32'h0 : i_bus_rdata;

  always_comb begin
    done_d   = {fin && owner_q, fin && !owner_q};
    err_d    = {fin_err && owner_q, fin_err && !owner_q};
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    if (upd_rdata && !owner_q) rdata0_d = fin_rdata;
    if (upd_rdata && owner_q)  rdata1_d = fin_rdata;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      done_q   <= '0;
      err_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      if (accept) begin
        owner_q <= gnt[1];
        we_q    <= sel_we;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
      end
    end
  end

  assign o_m0_gnt    = gnt[0];
  assign o_m1_gnt    = gnt[1];
  assign o_m0_done   = done_q[0];
  assign o_m1_done   = done_q[1];
  assign o_m0_err    = err_q[0];
  assign o_m1_err    = err_q[1];
  assign o_m0_rdata  = rdata0_q;
  assign o_m1_rdata  = rdata1_q;
  assign o_bus_valid = (state_q == StBusy);
  assign o_bus_we    = we_q;
  assign o_bus_addr  = addr_q;
  assign o_bus_wdata = wdata_q;
  assign o_bus_owner = owner_q;

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

  localparam int unsigned TMO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        o_m0_gnt, o_m0_done, o_m0_err, o_m1_gnt, o_m1_done, o_m1_err;
  logic [31:0] o_m0_rdata, o_m1_rdata;
  logic        o_bus_valid, o_bus_we, o_bus_owner;
  logic [31:0] o_bus_addr, o_bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ready;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned cyc   = 0;
  bit          rand_on = 1'b0;
  bit          acc0, acc1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  bus_arbiter #(.TIMEOUT(TMO)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_m0_req   (m0_req),
    .i_m0_we    (m0_we),
    .i_m0_addr  (m0_addr),
    .i_m0_wdata (m0_wdata),
    .o_m0_gnt   (o_m0_gnt),
    .o_m0_done  (o_m0_done),
    .o_m0_err   (o_m0_err),
    .o_m0_rdata (o_m0_rdata),
    .i_m1_req   (m1_req),
    .i_m1_we    (m1_we),
    .i_m1_addr  (m1_addr),
    .i_m1_wdata (m1_wdata),
    .o_m1_gnt   (o_m1_gnt),
    .o_m1_done  (o_m1_done),
    .o_m1_err   (o_m1_err),
    .o_m1_rdata (o_m1_rdata),
    .o_bus_valid(o_bus_valid),
    .o_bus_we   (o_bus_we),
    .o_bus_addr (o_bus_addr),
    .o_bus_wdata(o_bus_wdata),
    .i_bus_rdata(bus_rdata),
    .i_bus_ready(bus_ready),
    .o_bus_owner(o_bus_owner)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // Transaction phase: 0 none, 1 on the bus, 2 unmapped (answered with an error next cycle)
  int          tx_phase;
  bit          tx_own, tx_we;
  int          tx_age;          // cycles the command has been presented on the bus
  bit          last_served;     // master served most recently
  logic [1:0]  e_done, e_err, eg;
  logic [31:0] e_rd0, e_rd1, e_addr, e_wdata;
  bit          e_owner, e_we;
  logic [15:0] dev_map;

  task automatic model_reset();
    tx_phase = 0; tx_age = 0; last_served = 1'b1;
    e_done = '0; e_err = '0; e_rd0 = '0; e_rd1 = '0;
    e_addr = '0; e_wdata = '0; e_owner = 1'b0; e_we = 1'b0;
  endtask

  task automatic finish(input bit err);
    logic [31:0] v;
    v = err ? 32'h0 : bus_rdata;
    e_done[tx_own] = 1'b1;
    e_err[tx_own]  = err;
    if (err || !tx_we) begin
      if (tx_own) e_rd1 = v; else e_rd0 = v;
    end
    tx_phase = 0;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_gnt",   {o_m1_gnt, o_m0_gnt}, 0);
      chk("rst_flags", {o_m1_done, o_m1_err, o_m0_done, o_m0_err, o_bus_valid, o_bus_we,
                        o_bus_owner}, 0);
      chk("rst_addr",  o_bus_addr | o_bus_wdata, 0);
      chk("rst_rdata", o_m0_rdata | o_m1_rdata, 0);
      model_reset();
    end else begin
      eg = 2'b00;
      if (tx_phase == 0) begin
        if (m0_req && m1_req) eg = last_served ? 2'b01 : 2'b10;
        else                  eg = {m1_req, m0_req};
      end
      chk("gnt",   {o_m1_gnt, o_m0_gnt}, eg);
      chk("valid", o_bus_valid, tx_phase == 1);
      chk("owner", o_bus_owner, e_owner);
      chk("we",    o_bus_we, e_we);
      chk("addr",  o_bus_addr, e_addr);
      chk("wdata", o_bus_wdata, e_wdata);
      chk("done",  {o_m1_done, o_m0_done}, e_done);
      chk("err",   {o_m1_err, o_m0_err}, e_err);
      chk("rdata0", o_m0_rdata, e_rd0);
      chk("rdata1", o_m1_rdata, e_rd1);
      // Advance to the state after the coming rising edge.
      e_done = '0;
      e_err  = '0;
      if (tx_phase == 1) begin
        tx_age++;
        if (bus_ready)          finish(1'b0);
        else if (tx_age > TMO)  finish(1'b1);
      end else if (tx_phase == 2) begin
        finish(1'b1);
      end else if (eg != 2'b00) begin
        tx_own      = eg[1];
        last_served = eg[1];
        tx_we       = eg[1] ? m1_we : m0_we;
        e_owner     = eg[1];
        e_we        = tx_we;
        e_addr      = eg[1] ? m1_addr : m0_addr;
        e_wdata     = eg[1] ? m1_wdata : m0_wdata;
        tx_age      = 0;
        tx_phase    = dev_map[e_addr[31:28]] ? 1 : 2;
      end
    end
  end

  // ---------------- random stimulus ----------------
  always @(negedge clk) begin
    acc0 = m0_req & o_m0_gnt;
    acc1 = m1_req & o_m1_gnt;
  end

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    logic [3:0]  ids [5];
    ids = '{4'h0, 4'h4, 4'h5, 4'h6, 4'h8};
    a = $urandom;
    if ($urandom_range(0, 3) != 0) a[31:28] = ids[$urandom_range(0, 4)];
    return a;
  endfunction

  always @(posedge clk) begin
    if (rand_on) begin
      #1;
      if (!m0_req || acc0) begin
        m0_req = ($urandom_range(0, 2) != 0); m0_we = $urandom_range(0, 1);
        m0_addr = rand_addr(); m0_wdata = $urandom;
      end
      if (!m1_req || acc1) begin
        m1_req = ($urandom_range(0, 2) != 0); m1_we = $urandom_range(0, 1);
        m1_addr = rand_addr(); m1_wdata = $urandom;
      end
      bus_ready = ($urandom_range(0, 3) == 0);
      bus_rdata = $urandom;
    end
  end

  // ---------------- directed sequences ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int n, got;
    bit prev_w;
    dev_map = 16'h0171;  // ids 0, 4, 5, 6, 8
    model_reset();
    rst_n = 1'b0;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
    bus_ready = 0; bus_rdata = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Zero-wait read from M0.
    tick();
    m0_req = 1; m0_we = 0; m0_addr = 32'h0000_0010;
    @(negedge clk); chk("t1_gnt", o_m0_gnt, 1);
    tick();
    m0_req = 0; bus_ready = 1; bus_rdata = 32'h1234_5678;
    @(negedge clk); chk("t1_valid", o_bus_valid, 1); chk("t1_addr", o_bus_addr, 32'h10);
    tick();
    bus_ready = 0; bus_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("t1_done", o_m0_done, 1); chk("t1_rdata", o_m0_rdata, 32'h1234_5678);
    chk("t1_err", o_m0_err, 0);

    // Both masters request continuously from reset.
    pulse_reset();
    m0_req = 1; m0_we = 0; m0_addr = 32'h0000_0100;
    m1_req = 1; m1_we = 0; m1_addr = 32'h8000_0200;
    bus_ready = 1;
    n = 0; prev_w = 0;
    for (int c = 0; c < 20 && n < 4; c++) begin
      @(negedge clk);
      if (o_bus_valid) chk("t2_owner", o_bus_owner, prev_w);
      if (o_m0_gnt || o_m1_gnt) begin
        chk("t2_order", o_m1_gnt, n % 2);
        prev_w = o_m1_gnt;
        n++;
      end
      tick();
    end
    chk("t2_count", n, 4);
    m0_req = 0; m1_req = 0;
    repeat (3) tick();
    bus_ready = 0;

    // M1 write with three wait states.
    m1_req = 1; m1_we = 1; m1_addr = 32'h4000_0004; m1_wdata = 32'hA5A5_A5A5;
    @(negedge clk); chk("t3_gnt", o_m1_gnt, 1);
    tick();
    m1_req = 0;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) bus_ready = 1;
      @(negedge clk);
      chk("t3_valid", o_bus_valid, 1); chk("t3_addr", o_bus_addr, 32'h4000_0004);
      chk("t3_wdata", o_bus_wdata, 32'hA5A5_A5A5); chk("t3_we", o_bus_we, 1);
      tick();
    end
    bus_ready = 0;
    @(negedge clk);
    chk("t3_done", o_m1_done, 1); chk("t3_err", o_m1_err, 0);
    chk("t3_rdata_hold", o_m1_rdata, 32'hDEAD_BEEF);

    // Timeout on a hung device, with M1 waiting behind it.
    tick();
    m0_req = 1; m0_we = 0; m0_addr = 32'h5000_0000;
    @(negedge clk); chk("t4_gnt", o_m0_gnt, 1);
    tick();
    m0_req = 0; m1_req = 1; m1_we = 0; m1_addr = 32'h0000_0020;
    @(negedge clk); chk("t4_valid", o_bus_valid, 1);
    got = 0;
    for (int c = 1; c < 30; c++) begin
      tick();
      @(negedge clk);
      if (o_m0_done) begin got = c; break; end
    end
    chk("t4_latency", got, TMO + 1);
    chk("t4_err", o_m0_err, 1); chk("t4_rdata", o_m0_rdata, 0);
    chk("t4_next_gnt", o_m1_gnt, 1);
    tick();
    m1_req = 0; bus_ready = 1;
    tick();
    bus_ready = 0;
    @(negedge clk); chk("t4_m1_done", o_m1_done, 1);

    // Unmapped device id.
    tick();
    m1_req = 1; m1_we = 0; m1_addr = 32'h3000_0000;
    @(negedge clk); chk("t5_gnt", o_m1_gnt, 1); chk("t5_valid_n", o_bus_valid, 0);
    tick();
    m1_req = 0;
    @(negedge clk); chk("t5_valid_n1", o_bus_valid, 0); chk("t5_early", o_m1_done, 0);
    tick();
    @(negedge clk);
    chk("t5_valid_n2", o_bus_valid, 0); chk("t5_done", o_m1_done, 1);
    chk("t5_err", o_m1_err, 1); chk("t5_rdata", o_m1_rdata, 0);

    // Reset while a command is on the bus.
    tick();
    m0_req = 1; m0_we = 0; m0_addr = 32'h6000_0000;
    @(negedge clk); chk("t6_gnt", o_m0_gnt, 1);
    tick();
    m0_req = 0;
    @(negedge clk); chk("t6_busy", o_bus_valid, 1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", o_bus_valid, 0); chk("t6_async_addr", o_bus_addr, 0);
    chk("t6_async_rdata", o_m0_rdata | o_m1_rdata, 0);
    tick();
    rst_n = 1'b1;
    m0_req = 1; m0_addr = 32'h0000_0000; m1_req = 1; m1_we = 0; m1_addr = 32'h8000_0000;
    @(negedge clk);
    chk("t6_gnt_m0", {o_m1_gnt, o_m0_gnt}, 2'b01); chk("t6_no_done", o_m0_done, 0);
    tick();
    m0_req = 0; m1_req = 0; bus_ready = 1;
    repeat (4) tick();
    bus_ready = 0;

    // Randomized traffic with a reset in the middle.
    rand_on = 1'b1;
    repeat (1500) @(posedge clk);
    pulse_reset();
    repeat (1500) @(posedge clk);
    rand_on = 1'b0;
    #2;
    m0_req = 0; m1_req = 0; bus_ready = 1;
    repeat (TMO + 6) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master arbiter and transaction sequencer for the SoC peripheral bus. It shares one bus between master 0 (core load/store port) and master 1 (DMA engine). It registers the winning command, holds it on the bus until the addressed device answers, and returns read data and status to the owner. It sits upstream of `device_sel`, drives the address whose `[31:28]` field selects the device, and protects masters from hung or unmapped devices with a timeout and an address check.

## Interface
Parameters:
- `TIMEOUT`, 255: maximum cycles `o_bus_valid` may stay high without `i_bus_ready` before the transaction is aborted (≥2).
- `TO_W`, `$clog2(TIMEOUT+1)`: timeout counter width (derived, not overridden).

Ports:
- `i_clk`  in  1  system clock, rising edge
- `i_rst_n`  in  1  asynchronous active-low reset
- `i_m0_req`  in  1  master 0 command valid; held with payload until `o_m0_gnt`
- `i_m0_we`  in  1  1 = write, 0 = read
- `i_m0_addr`  in  32  byte address; `[31:28]` = device id
- `i_m0_wdata`  in  32  write data
- `o_m0_gnt`  out  1  command accepted this cycle (combinational)
- `o_m0_done`  out  1  one-cycle completion pulse (registered)
- `o_m0_err`  out  1  valid with `o_m0_done`: timeout or unmapped
- `o_m0_rdata`  out  32  read data, valid with `o_m0_done`
- `i_m1_*` / `o_m1_*`: identical set for master 1 (DMA)
- `o_bus_valid`  out  1  command on bus
- `o_bus_we`  out  1  registered write enable
- `o_bus_addr`  out  32  registered address (feeds device decode)
- `o_bus_wdata`  out  32  registered write data
- `i_bus_rdata`  in  32  muxed device read data
- `i_bus_ready`  in  1  device completes the current command this cycle
- `o_bus_owner`  out  1  master owning the bus (0/1)

## Operation
- FSM states:
  - `IDLE`: arbitration.
  - `BUSY`: command on bus.
  - `FAULT`: one cycle, unmapped address.
- Arbitration, in `IDLE` only:
  - Single requester wins.
  - If both request, the master not served last wins (round-robin pointer). After reset the pointer favours M0.
- Acceptance (`IDLE`, `gnt` high):
  - Capture `we`/`addr`/`wdata` into the bus registers and set `o_bus_owner`.
  - Update the pointer.
  - Device id in {0x0, 0x4, 0x5, 0x6, 0x8} → `BUSY`; otherwise → `FAULT`.
- `BUSY`:
  - `o_bus_valid`=1 and all bus fields stable.
  - Counter increments each cycle without `i_bus_ready`.
  - On `i_bus_ready`: owner's `done`=1 and `err`=0 next cycle. Reads load `rdata` from `i_bus_rdata`; writes leave `rdata` unchanged. Go to `IDLE`.
  - If the counter reaches `TIMEOUT` with no ready: `done`=1, `err`=1, `rdata`=0, go to `IDLE`.
- `FAULT`:
  - `o_bus_valid` stays 0.
  - Next cycle `done`=1, `err`=1, `rdata`=0.
  - Go to `IDLE`.
- Non-owner outputs: `done`/`err` stay 0 and `rdata` holds.
- Masters may hold `req` high continuously for back-to-back commands.
- `i_bus_ready` is ignored outside `BUSY`.
- Reset (any time, including mid-`BUSY`):
  - All outputs 0, state `IDLE`, counter 0, pointer → M0.
  - The in-flight command is dropped with no `done`.

## Timing
- Request seen in `IDLE` at cycle N:
  - `gnt` in cycle N.
  - `o_bus_valid` from N+1.
  - Zero-wait device answers at N+1, so `done` at N+2.
- Each device wait state adds one cycle. Peak throughput is one transfer per 2 cycles.
- `done` is asserted in the same cycle the FSM returns to `IDLE`, so a new `gnt` can occur in that cycle.
- `o_bus_valid` deasserts the cycle after `i_bus_ready`.
- Timeout: `done`/`err` arrive `TIMEOUT`+1 cycles after `o_bus_valid` rose.
- Unmapped address: `done`/`err` at N+2, with `o_bus_valid` never high.

## Structure
- Package `soc_bus_pkg` holds:
  - device-id constants (`DEV_RAM`=0x0, `DEV_GPIO`=0x4, `DEV_UART`=0x5, `DEV_TIMER`=0x6, `DEV_SPI`=0x8);
  - state enum;
  - `is_mapped()` function.
  Shared with `device_sel` so the decode cannot diverge.
- Sub-module `rr_arb2`: combinational 2-way round-robin grant with registered pointer.
- Everything else stays flat in `bus_arbiter`.

## Test plan
- M0 read 0x0000_0010, device ready in first valid cycle with 0x1234_5678 → `gnt` N, `valid` N+1, `o_m0_done` N+2 with `rdata` 0x1234_5678, `err` 0.
- M0 and M1 both hold `req` from reset for 4 transfers → grants M0, M1, M0, M1; `o_bus_owner` matches; each `done` goes only to its owner.
- M1 write 0x4000_0004 = 0xA5A5_A5A5, ready after 3 wait states → `addr`/`wdata`/`we` stable 4 cycles, `o_m1_done` the next cycle, `o_m1_rdata` unchanged.
- M0 read 0x5000_0000, ready never asserted, `TIMEOUT`=8 → `done` and `err`=1 with `rdata` 0 exactly 9 cycles after `valid` rose; a following M1 request is granted in the same cycle.
- M1 read 0x3000_0000 (unmapped) → `o_bus_valid` never high, `done` and `err`=1 two cycles after request.
- `i_rst_n` low for 1 cycle mid-`BUSY` → all outputs 0 immediately, no `done` for the dropped command, next simultaneous request is granted to M0.
